// File: rtl/rv_core_mc.sv
// Multi-cycle RV32I-subset core: fetches over a valid/ready port, executes in one cycle,
// and stops on EBREAK or an illegal instruction. A debug tap mirrors every register write.
module rv_core_mc #(
   parameter int          NREG     = 32,
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] pc,
   output logic        halt,
   output logic        illegal,
   output logic        dbg_wen,
   output logic [4:0]  dbg_waddr,
   output logic [31:0] dbg_wdata
);
   localparam int AW = (NREG == 16) ? 4 : 5;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_EXEC  = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] OP_REG = 7'h33;
   localparam logic [6:0] OP_LUI = 7'h37;
   localparam logic [6:0] OP_AUI = 7'h17;
   localparam logic [6:0] OP_JAL = 7'h6F;
   localparam logic [6:0] OP_JLR = 7'h67;
   localparam logic [6:0] OP_SYS = 7'h73;

   logic [1:0]  state_reg;
   logic [31:0] pc_reg;
   logic [31:0] instr_reg;
   logic        halt_reg;
   logic        illegal_reg;
   logic        dbg_wen_reg;
   logic [4:0]  dbg_waddr_reg;
   logic [31:0] dbg_wdata_reg;

   logic [31:0] regs [NREG];

   logic [6:0]  opcode;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i;
   logic [31:0] imm_u;
   logic [31:0] imm_j;
   logic [31:0] rs1_val;
   logic [31:0] rs2_val;
   logic [31:0] pc_plus4;
   logic [31:0] jalr_sum;

   logic        legal;
   logic        writes_rd;
   logic        uses_rs1;
   logic        uses_rs2;
   logic        is_ebreak;
   logic        is_jump;
   logic [31:0] wb_data;
   logic [31:0] next_pc;
   logic        rf_we;

   assign opcode = instr_reg[6:0];
   assign rd     = instr_reg[11:7];
   assign funct3 = instr_reg[14:12];
   assign rs1    = instr_reg[19:15];
   assign rs2    = instr_reg[24:20];
   assign funct7 = instr_reg[31:25];

   assign imm_i = {{20{instr_reg[31]}}, instr_reg[31:20]};
   assign imm_u = {instr_reg[31:12], 12'h000};
   assign imm_j = {{12{instr_reg[31]}}, instr_reg[19:12], instr_reg[20], instr_reg[30:21], 1'b0};

   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs[rs1[AW-1:0]];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs[rs2[AW-1:0]];
   assign pc_plus4 = pc_reg + 32'd4;
   assign jalr_sum = rs1_val + imm_i;

   always_comb begin
      legal     = 1'b0;
      writes_rd = 1'b0;
      uses_rs1  = 1'b0;
      uses_rs2  = 1'b0;
      is_ebreak = 1'b0;
      is_jump   = 1'b0;
      wb_data   = 32'd0;
      next_pc   = pc_plus4;
      case (opcode)
         OP_IMM: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            uses_rs1  = 1'b1;
            case (funct3)
               3'b000:  wb_data = rs1_val + imm_i;
               3'b010:  wb_data = {31'd0, ($signed(rs1_val) < $signed(imm_i))};
               3'b100:  wb_data = rs1_val ^ imm_i;
               3'b110:  wb_data = rs1_val | imm_i;
               3'b111:  wb_data = rs1_val & imm_i;
               default: legal = 1'b0;
            endcase
         end
         OP_REG: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            uses_rs1  = 1'b1;
            uses_rs2  = 1'b1;
            if (funct7 == 7'h00) begin
               case (funct3)
                  3'b000:  wb_data = rs1_val + rs2_val;
                  3'b100:  wb_data = rs1_val ^ rs2_val;
                  3'b110:  wb_data = rs1_val | rs2_val;
                  3'b111:  wb_data = rs1_val & rs2_val;
                  default: legal = 1'b0;
               endcase
            end else if (funct7 == 7'h20 && funct3 == 3'b000) begin
               wb_data = rs1_val - rs2_val;
            end else begin
               legal = 1'b0;
            end
         end
         OP_LUI: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            wb_data   = imm_u;
         end
         OP_AUI: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            wb_data   = pc_reg + imm_u;
         end
         OP_JAL: begin
            legal     = 1'b1;
            writes_rd = 1'b1;
            is_jump   = 1'b1;
            wb_data   = pc_plus4;
            next_pc   = pc_reg + imm_j;
         end
         OP_JLR: begin
            legal     = (funct3 == 3'b000);
            writes_rd = 1'b1;
            uses_rs1  = 1'b1;
            is_jump   = 1'b1;
            wb_data   = pc_plus4;
            next_pc   = jalr_sum & ~32'd1;
         end
         OP_SYS: begin
            legal     = (instr_reg == 32'h0010_0073);
            is_ebreak = legal;
         end
         default: legal = 1'b0;
      endcase
      // RV32E: only fields the format actually uses are range-checked
      if (NREG == 16 && ((uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4]) || (writes_rd && rd[4])))
         legal = 1'b0;
      if (is_jump && next_pc[1])
         legal = 1'b0;
   end

   assign rf_we = (state_reg == ST_EXEC) && legal && writes_rd && (rd != 5'd0);

   // Register contents survive reset; only the write port is gated by the FSM.
   always_ff @(posedge clk) begin
      if (rf_we)
         regs[rd[AW-1:0]] <= wb_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= ST_FETCH;
         pc_reg        <= RESET_PC;
         instr_reg     <= 32'd0;
         halt_reg      <= 1'b0;
         illegal_reg   <= 1'b0;
         dbg_wen_reg   <= 1'b0;
         dbg_waddr_reg <= 5'd0;
         dbg_wdata_reg <= 32'd0;
      end else begin
         dbg_wen_reg <= rf_we;
         if (rf_we) begin
            dbg_waddr_reg <= rd;
            dbg_wdata_reg <= wb_data;
         end
         case (state_reg)
            ST_FETCH: if (imem_req_ready) state_reg <= ST_WAIT;
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  instr_reg <= imem_rsp_data;
                  state_reg <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (!legal) begin
                  halt_reg    <= 1'b1;
                  illegal_reg <= 1'b1;
                  state_reg   <= ST_HALT;
               end else if (is_ebreak) begin
                  halt_reg  <= 1'b1;
                  state_reg <= ST_HALT;
               end else begin
                  pc_reg    <= next_pc;
                  state_reg <= ST_FETCH;
               end
            end
            default: state_reg <= ST_HALT;
         endcase
      end
   end

   assign imem_req_valid = (state_reg == ST_FETCH);
   assign imem_addr      = pc_reg;
   assign pc             = pc_reg;
   assign halt           = halt_reg;
   assign illegal        = illegal_reg;
   assign dbg_wen        = dbg_wen_reg;
   assign dbg_waddr      = dbg_waddr_reg;
   assign dbg_wdata      = dbg_wdata_reg;
endmodule

// File: tb/tb_rv_core_mc.sv
// Directed + randomized bench for rv_core_mc: a 32-register core is checked against an
// instruction-level reference model; a 16-register twin shares its fetch port for RV32E checks.
module tb_rv_core_mc;
   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'd0;

   logic        imem_req_valid, halt, illegal, dbg_wen;
   logic [31:0] imem_addr, pc, dbg_wdata;
   logic [4:0]  dbg_waddr;

   logic        e_req_valid, e_halt, e_illegal, e_dbg_wen;
   logic [31:0] e_addr, e_pc, e_dbg_wdata;
   logic [4:0]  e_dbg_waddr;

   int checks = 0;
   int errors = 0;
   int last_pulses_e;

   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   bit          m_halt;
   bit          m_illegal;

   always #5 clk = ~clk;

   rv_core_mc #(.NREG(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .pc(pc), .halt(halt), .illegal(illegal),
      .dbg_wen(dbg_wen), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata)
   );

   rv_core_mc #(.NREG(16), .RESET_PC(RESET_PC)) dut_e (
      .clk(clk), .rst(rst),
      .imem_req_valid(e_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(e_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .pc(e_pc), .halt(e_halt), .illegal(e_illegal),
      .dbg_wen(e_dbg_wen), .dbg_waddr(e_dbg_waddr), .dbg_wdata(e_dbg_wdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   // Instruction-level reference: one call retires one instruction on the architectural state.
   task automatic model_step(input logic [31:0] ins, output bit wen, output logic [4:0] wa,
                             output logic [31:0] wd);
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] a, b, immi, immj, res, npc;
      bit ok, wr, jump;
      rd = ins[11:7]; rs1 = ins[19:15]; rs2 = ins[24:20]; f3 = ins[14:12]; f7 = ins[31:25];
      a = m_regs[rs1]; b = m_regs[rs2];
      immi = {{20{ins[31]}}, ins[31:20]};
      immj = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      wen = 0; wa = 0; wd = 0; ok = 1; wr = 0; jump = 0; res = 0; npc = m_pc + 32'd4;
      if (ins == 32'h0010_0073) begin
         m_halt = 1;
         return;
      end
      case (ins[6:0])
         7'h13: begin
            wr = 1;
            if (f3 == 3'd0)      res = a + immi;
            else if (f3 == 3'd2) res = ($signed(a) < $signed(immi)) ? 32'd1 : 32'd0;
            else if (f3 == 3'd4) res = a ^ immi;
            else if (f3 == 3'd6) res = a | immi;
            else if (f3 == 3'd7) res = a & immi;
            else ok = 0;
         end
         7'h33: begin
            wr = 1;
            if (f7 == 7'h00 && f3 == 3'd0)      res = a + b;
            else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
            else if (f7 == 7'h00 && f3 == 3'd4) res = a ^ b;
            else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
            else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
            else ok = 0;
         end
         7'h37: begin wr = 1; res = {ins[31:12], 12'h000}; end
         7'h17: begin wr = 1; res = m_pc + {ins[31:12], 12'h000}; end
         7'h6F: begin wr = 1; jump = 1; res = m_pc + 32'd4; npc = m_pc + immj; end
         7'h67: begin
            wr = 1; jump = 1; res = m_pc + 32'd4;
            npc = (a + immi) & 32'hFFFF_FFFE;
            if (f3 != 3'd0) ok = 0;
         end
         default: ok = 0;
      endcase
      if (jump && npc[1]) ok = 0;
      if (!ok) begin
         m_halt = 1;
         m_illegal = 1;
      end else begin
         if (wr && rd != 5'd0) begin
            m_regs[rd] = res;
            wen = 1; wa = rd; wd = res;
         end
         m_pc = npc;
      end
   endtask

   // One instruction through the fetch port; called and returning on a falling edge.
   task automatic xact(input logic [31:0] ins, input int rdly, input int vdly);
      bit ew;
      logic [4:0] ea;
      logic [31:0] ed;
      int pulses, pulses_e, req_drop, req_wait;
      pulses = 0; pulses_e = 0; req_drop = 0; req_wait = 0;
      chk("fetch_req", 32'(imem_req_valid), 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      model_step(ins, ew, ea, ed);
      for (int i = 0; i < rdly; i++) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = $urandom;
         @(negedge clk);
         pulses += int'(dbg_wen); pulses_e += int'(e_dbg_wen);
         if (!imem_req_valid) req_drop++;
      end
      imem_rsp_valid = 1'b0;
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      pulses += int'(dbg_wen); pulses_e += int'(e_dbg_wen);
      if (imem_req_valid) req_wait++;
      for (int i = 0; i < vdly; i++) begin
         @(negedge clk);
         pulses += int'(dbg_wen); pulses_e += int'(e_dbg_wen);
         if (imem_req_valid) req_wait++;
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data = ins;
      @(negedge clk);
      imem_rsp_valid = 1'b0;
      imem_rsp_data = 32'd0;
      pulses += int'(dbg_wen); pulses_e += int'(e_dbg_wen);
      if (imem_req_valid) req_wait++;
      @(negedge clk);
      pulses += int'(dbg_wen); pulses_e += int'(e_dbg_wen);
      $display("xact ins=%08h stall=%0d/%0d wen=%0d x%0d=%08h pc=%08h halt=%0b ill=%0b",
               ins, rdly, vdly, dbg_wen, dbg_waddr, dbg_wdata, pc, halt, illegal);
      chk("req_held_in_fetch", 32'(req_drop), 32'd0);
      chk("req_after_accept", 32'(req_wait), 32'd0);
      chk("wen_pulses", 32'(pulses), 32'(ew));
      if (ew) begin
         chk("dbg_waddr", 32'(dbg_waddr), 32'(ea));
         chk("dbg_wdata", dbg_wdata, ed);
      end
      chk("pc", pc, m_pc);
      chk("halt", 32'(halt), 32'(m_halt));
      chk("illegal", 32'(illegal), 32'(m_illegal));
      last_pulses_e = pulses_e;
   endtask

   // Asynchronous reset pulse raised between clock edges; starts and ends on a falling edge.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_pc", pc, RESET_PC);
      chk("rst_halt", 32'(halt), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_dbg_wen", 32'(dbg_wen), 32'd0);
      chk("rst_e_halt", 32'(e_halt), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      m_pc = RESET_PC; m_halt = 0; m_illegal = 0;
      @(negedge clk);
      $display("reset released pc=%08h", pc);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [2:0] f3s [5] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd7};
      logic [2:0] rf3 [4] = '{3'd0, 3'd4, 3'd6, 3'd7};
      logic [4:0] rd, rs1, rs2;
      logic [31:0] r;
      rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      r = $urandom;
      case ($urandom_range(0, 11))
         0, 1, 2: return enc_i(r[11:0], rs1, f3s[$urandom_range(0, 4)], rd, 7'h13);
         3, 4:    return enc_r(7'h00, rs2, rs1, rf3[$urandom_range(0, 3)], rd);
         5:       return enc_r(7'h20, rs2, rs1, 3'd0, rd);
         6:       return {r[31:12], rd, 7'h37};
         7:       return {r[31:12], rd, 7'h17};
         8:       return enc_j({r[20:1], 1'b0}, rd);
         9:       return enc_i(r[11:0], rs1, 3'd0, rd, 7'h67);
         10:      return 32'h0010_0073;
         default: return r;
      endcase
   endfunction

   initial begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pc = RESET_PC; m_halt = 0; m_illegal = 0;

      // reset state
      @(negedge clk);
      chk("reset_pc", pc, RESET_PC);
      chk("reset_halt", 32'(halt), 32'd0);
      chk("reset_illegal", 32'(illegal), 32'd0);
      chk("reset_dbg_wen", 32'(dbg_wen), 32'd0);
      chk("reset_dbg_waddr", 32'(dbg_waddr), 32'd0);
      chk("reset_dbg_wdata", dbg_wdata, 32'd0);
      chk("reset_req_valid", 32'(imem_req_valid), 32'd1);
      rst = 1'b0;
      @(negedge clk);

      // handshake and ALU chain
      xact(32'h0050_0093, 0, 0);
      chk("e_handshake_write", 32'(last_pulses_e), 32'd1);
      xact(32'h0010_8133, 0, 0);
      xact(32'h4011_01B3, 0, 0);
      xact(32'h1234_52B7, 0, 0);
      chk("x5_lui", m_regs[5], 32'h1234_5000);

      // give every register a known value
      for (int r = 4; r < 32; r++)
         if (r != 5) xact(enc_i(12'($urandom), 5'd0, 3'd0, 5'(r), 7'h13), 0, 0);

      // pc wrap from 0xFFFFFFFC to 0
      xact(32'hFFC0_0393, 0, 0);
      xact(32'h0003_8067, 1, 1);
      chk("pc_at_top", pc, 32'hFFFF_FFFC);
      xact(32'h0010_0413, 0, 0);
      chk("pc_wrapped", pc, 32'd0);

      // randomized stream against the model
      for (int n = 0; n < 150; n++) begin
         xact(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 2));
         if (m_halt) do_reset();
      end

      // stalls and jump, then misaligned jump target
      do_reset();
      xact(32'h0080_00EF, 4, 3);
      xact(32'h0060_01EF, 0, 0);
      chk("misaligned_illegal", 32'(illegal), 32'd1);

      // EBREAK halt, then reset out of HALT
      do_reset();
      xact(32'h0010_0073, 0, 0);
      begin
         int req_seen, pc_moved;
         req_seen = 0; pc_moved = 0;
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_req_valid) req_seen++;
            if (pc !== RESET_PC) pc_moved++;
         end
         chk("halt_no_req", 32'(req_seen), 32'd0);
         chk("halt_pc_stable", 32'(pc_moved), 32'd0);
      end
      do_reset();

      // RV32E register limit
      xact(32'h0010_0813, 0, 0);
      chk("x16_written_rv32i", m_regs[16], 32'd1);
      chk("e_illegal", 32'(e_illegal), 32'd1);
      chk("e_halt", 32'(e_halt), 32'd1);
      chk("e_no_write", 32'(last_pulses_e), 32'd0);

      // reset during WAIT, then restart from the reset PC
      do_reset();
      xact(32'h0070_0093, 0, 0);
      imem_req_ready = 1'b1;
      @(negedge clk);
      imem_req_ready = 1'b0;
      chk("in_wait_no_req", 32'(imem_req_valid), 32'd0);
      do_reset();
      xact(32'h0090_0113, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
